// File: rtl/seg7_capture_pkg.sv
// Shared constants for the seven-segment capture path: active-low segment
// patterns (bit 6 = g, bit 0 = a) and the dwell tracker state encoding.
package seg7_capture_pkg;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    // Decoded view of one segment pattern.
    typedef struct packed {
        logic       legal;
        logic [3:0] nibble;
    } hex_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational inverse of the hex-to-seven-segment table; legal is low for
// any pattern outside the sixteen hex glyphs.
module seg7_to_hex
    import seg7_capture_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       legal
);

    hex_t dec;

    always_comb begin
        dec = '{legal: 1'b1, nibble: 4'h0};
        case (seg)
            SEG_0:   dec.nibble = 4'h0;
            SEG_1:   dec.nibble = 4'h1;
            SEG_2:   dec.nibble = 4'h2;
            SEG_3:   dec.nibble = 4'h3;
            SEG_4:   dec.nibble = 4'h4;
            SEG_5:   dec.nibble = 4'h5;
            SEG_6:   dec.nibble = 4'h6;
            SEG_7:   dec.nibble = 4'h7;
            SEG_8:   dec.nibble = 4'h8;
            SEG_9:   dec.nibble = 4'h9;
            SEG_A:   dec.nibble = 4'hA;
            SEG_B:   dec.nibble = 4'hB;
            SEG_C:   dec.nibble = 4'hC;
            SEG_D:   dec.nibble = 4'hD;
            SEG_E:   dec.nibble = 4'hE;
            SEG_F:   dec.nibble = 4'hF;
            default: dec = '{legal: 1'b0, nibble: 4'h0};
        endcase
    end

    assign nibble = dec.nibble;
    assign legal  = dec.legal;

endmodule

// File: rtl/seg7_capture.sv
// Watches a multiplexed seven-segment bus and recovers the nibble on each
// digit once its pattern has dwelt unchanged for STABLE_CYCLES samples.
module seg7_capture
    import seg7_capture_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int IDX_W         = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_done,
    output logic                    bad_pattern,
    output logic [IDX_W-1:0]        bad_digit,
    output logic                    sel_err
);

    localparam logic [7:0] CAP_AT = 8'(STABLE_CYCLES - 1);

    state_t                         state;
    logic [7:0]                     count;
    logic [NUM_DIGITS-1:0]          seen;
    logic [6:0]                     prev_seg;
    logic [NUM_DIGITS-1:0]          prev_sel;
    logic [NUM_DIGITS-1:0][3:0]     nib_q;

    logic                           onehot;
    logic                           same;
    logic                           cap_hit;
    logic [IDX_W-1:0]               sel_idx;
    logic [NUM_DIGITS-1:0]          seen_nxt;
    logic [3:0]                     dec_nib;
    logic                           dec_legal;

    seg7_to_hex u_dec (
        .seg    (seg),
        .nibble (dec_nib),
        .legal  (dec_legal)
    );

    assign onehot = ($countones(dig_sel) == 1);
    assign same   = (seg == prev_seg) && (dig_sel == prev_sel);
    // The sample that brings the dwell to STABLE_CYCLES captures in the same edge.
    assign cap_hit  = onehot && same && (state == ST_COUNT) && (count == CAP_AT);
    assign seen_nxt = seen | dig_sel;

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (dig_sel[i]) sel_idx = IDX_W'(i);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            count       <= '0;
            seen        <= '0;
            prev_seg    <= '0;
            prev_sel    <= '0;
            nib_q       <= '0;
            digit_valid <= '0;
            frame_done  <= 1'b0;
            bad_pattern <= 1'b0;
            bad_digit   <= '0;
            sel_err     <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            bad_pattern <= 1'b0;
            sel_err     <= 1'b0;

            if (!onehot) begin
                state   <= ST_IDLE;
                count   <= '0;
                sel_err <= 1'b1;
            end else if (state == ST_IDLE || !same) begin
                prev_seg <= seg;
                prev_sel <= dig_sel;
                count    <= 8'd1;
                state    <= ST_COUNT;
            end else if (state == ST_COUNT) begin
                count <= count + 8'd1;
                if (cap_hit) state <= ST_HELD;
            end

            if (cap_hit) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (dig_sel[i]) begin
                        digit_valid[i] <= dec_legal;
                        if (dec_legal) nib_q[i] <= dec_nib;
                    end
                end
                if (!dec_legal) begin
                    bad_pattern <= 1'b1;
                    bad_digit   <= sel_idx;
                end
                // A capture completing the frame also opens the next one.
                if (&seen_nxt) begin
                    frame_done <= 1'b1;
                    seen       <= '0;
                end else begin
                    seen <= seen_nxt;
                end
            end
        end
    end

    assign value = nib_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed plus randomized bench for seg7_capture, checked each cycle against
// a dwell-length reference model of the segment bus.
module tb_seg7_capture;

    localparam int ND = 4;
    localparam int S  = 4;
    localparam int IW = 2;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [6:0]      seg = 7'h7F;
    logic [ND-1:0]   dig_sel = '0;
    logic [4*ND-1:0] value;
    logic [ND-1:0]   digit_valid;
    logic            frame_done;
    logic            bad_pattern;
    logic [IW-1:0]   bad_digit;
    logic            sel_err;

    seg7_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(S), .IDX_W(IW)) dut (
        .clock       (clock),
        .reset       (reset),
        .seg         (seg),
        .dig_sel     (dig_sel),
        .value       (value),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .bad_pattern (bad_pattern),
        .bad_digit   (bad_digit),
        .sel_err     (sel_err)
    );

    always #5 clock = ~clock;

    logic [6:0] pat [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    int vectors = 0, miscompares = 0, checks = 0;
    int frames = 0, bads = 0;

    // Reference model: dwell length of the current (seg, dig_sel) pair.
    logic [3:0]    m_nib [ND];
    logic [ND-1:0] m_valid, m_seen;
    logic          m_frame, m_bad, m_selerr;
    logic [IW-1:0] m_bad_digit;
    int            run;
    logic [6:0]    m_pseg;
    logic [ND-1:0] m_psel;

    function automatic int decode(input logic [6:0] s);
        for (int k = 0; k < 16; k++)
            if (pat[k] == s) return k;
        return -1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < ND; i++) m_nib[i] = 4'h0;
        m_valid = '0; m_seen = '0; m_frame = 0; m_bad = 0; m_selerr = 0;
        m_bad_digit = '0; run = 0; m_pseg = '0; m_psel = '0;
    endtask

    task automatic model_update(input logic r, input logic [6:0] s, input logic [ND-1:0] d);
        int idx, k;
        if (r) begin
            model_clear();
            return;
        end
        m_frame = 0; m_bad = 0; m_selerr = 0;
        if ($countones(d) != 1) begin
            run = 0;
            m_selerr = 1;
        end else if (run > 0 && s == m_pseg && d == m_psel) begin
            run++;
        end else begin
            run = 1; m_pseg = s; m_psel = d;
        end
        if (run == S) begin
            idx = $clog2(d);
            k = decode(s);
            if (k >= 0) begin
                m_nib[idx] = 4'(k);
                m_valid[idx] = 1'b1;
            end else begin
                m_valid[idx] = 1'b0;
                m_bad = 1;
                m_bad_digit = IW'(idx);
            end
            m_seen[idx] = 1'b1;
            if (&m_seen) begin
                m_frame = 1;
                m_seen = '0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (vector %0d)", tag, got, exp, vectors);
        end
    endtask

    task automatic step(input logic r, input logic [6:0] s, input logic [ND-1:0] d);
        reset = r; seg = s; dig_sel = d;
        @(posedge clock); #1;
        vectors++;
        model_update(r, s, d);
        check("value", 32'(value), 32'({m_nib[3], m_nib[2], m_nib[1], m_nib[0]}));
        check("digit_valid", 32'(digit_valid), 32'(m_valid));
        check("frame_done", 32'(frame_done), 32'(m_frame));
        check("bad_pattern", 32'(bad_pattern), 32'(m_bad));
        check("bad_digit", 32'(bad_digit), 32'(m_bad_digit));
        check("sel_err", 32'(sel_err), 32'(m_selerr));
        frames += int'(frame_done);
        bads   += int'(bad_pattern);
    endtask

    initial begin
        int f0, b0, len;
        logic [6:0] rs;
        logic [ND-1:0] rd;
        logic rr;
        model_clear();

        // Reset state
        step(1, 7'h7F, 4'b0000);
        step(1, 7'h7F, 4'b0000);
        check("rst_value", 32'(value), 32'h0);

        // Digit 0 shows "2" for exactly the qualification window
        for (int j = 0; j < 4; j++) step(0, 7'b0100100, 4'b0001);
        check("p1_nib0", 32'(value[3:0]), 32'h2);
        check("p1_valid", 32'(digit_valid), 32'b0001);

        // Sweep 1, A, 7, F across digits 0..3
        f0 = frames;
        for (int j = 0; j < 6; j++) step(0, 7'b1111001, 4'b0001);
        for (int j = 0; j < 6; j++) step(0, 7'b0001000, 4'b0010);
        for (int j = 0; j < 6; j++) step(0, 7'b1111000, 4'b0100);
        for (int j = 0; j < 6; j++) step(0, 7'b0001110, 4'b1000);
        check("p2_value", 32'(value), 32'hF7A1);
        check("p2_valid", 32'(digit_valid), 32'hF);
        check("p2_frames", 32'(frames - f0), 32'd1);

        // Blank (illegal) pattern on digit 2
        b0 = bads;
        for (int j = 0; j < 5; j++) step(0, 7'b1111111, 4'b0100);
        check("p3_bads", 32'(bads - b0), 32'd1);
        check("p3_bad_digit", 32'(bad_digit), 32'd2);
        check("p3_valid", 32'(digit_valid), 32'b1011);
        check("p3_value", 32'(value), 32'hF7A1);

        // Toggling faster than the window never captures
        b0 = bads;
        for (int j = 0; j < 12; j++) step(0, ((j / 3) % 2 == 0) ? 7'b0000000 : 7'b0010000, 4'b0010);
        check("p4_value", 32'(value), 32'hF7A1);
        check("p4_bads", 32'(bads - b0), 32'd0);

        // Multi-hot then zero select, then a full-length dwell
        step(0, 7'b0110000, 4'b0011);
        check("p5_selerr_multi", 32'(sel_err), 32'd1);
        step(0, 7'b0110000, 4'b0000);
        check("p5_selerr_zero", 32'(sel_err), 32'd1);
        for (int j = 0; j < 3; j++) step(0, 7'b0110000, 4'b0001);
        check("p5_early", 32'(value[3:0]), 32'h1);
        step(0, 7'b0110000, 4'b0001);
        check("p5_capture", 32'(value[3:0]), 32'h3);

        // Reset mid-dwell restarts the count
        step(0, 7'b0010010, 4'b1000);
        step(0, 7'b0010010, 4'b1000);
        step(1, 7'b0010010, 4'b1000);
        check("p6_rst_value", 32'(value), 32'h0);
        check("p6_rst_valid", 32'(digit_valid), 32'h0);
        for (int j = 0; j < 3; j++) step(0, 7'b0010010, 4'b1000);
        check("p6_early", 32'(value[15:12]), 32'h0);
        step(0, 7'b0010010, 4'b1000);
        check("p6_capture", 32'(value[15:12]), 32'h5);

        // Randomized dwells
        for (int n = 0; n < 600; n++) begin
            len = $urandom_range(1, 8);
            if ($urandom_range(0, 9) == 0) rd = 4'($urandom_range(0, 15));
            else rd = 4'b0001 << $urandom_range(0, 3);
            if ($urandom_range(0, 5) == 0) rs = 7'($urandom);
            else rs = pat[$urandom_range(0, 15)];
            rr = ($urandom_range(0, 49) == 0);
            for (int j = 0; j < len; j++) step(rr && j == 0, rs, rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
